// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame checker: FSM state encoding and default sizes.
// Pure declarations, no timing or flow-control behaviour.
package parity_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_FRAME_LEN = 16;
  localparam int DEF_CNT_W     = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/parity_calc.sv
// Even-parity check of one word against its received parity bit; purely combinational,
// zero latency, no flow control.
module parity_calc
  import parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_parity,
  output logic              o_err
);

  assign o_err = (^i_data) ^ i_parity;

endmodule

// File: rtl/parity_frame_checker.sv
// Frame sequencer: checks FRAME_LEN words, forwards them tagged with m_error (1-cycle latency),
// stalls upstream while the output register is full. PARITY_IRQ_EN adds a sticky err_irq.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_parity,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_error,
  output logic              frame_done,
`ifdef PARITY_IRQ_EN
  output logic              err_irq,
`endif
  output logic [CNT_W-1:0]  frame_err_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [CNT_W-1:0]    r_run_cnt;
  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_error;
  logic                r_frame_done;
  logic [CNT_W-1:0]    r_frame_err_cnt;
`ifdef PARITY_IRQ_EN
  logic                r_err_irq;
`endif

  logic w_err;
  logic w_out_free;
  logic w_xfer;
  logic w_last;

  parity_calc #(.DATA_W(DATA_W)) u_calc (
    .i_data   (s_data),
    .i_parity (s_parity),
    .o_err    (w_err)
  );

  // Ready depends only on state, the output register and m_ready, never on s_valid.
  assign w_out_free = !r_m_valid | m_ready;
  assign s_ready    = (r_state == RUN) & w_out_free;
  assign w_xfer     = s_valid & s_ready;
  assign w_last     = (r_word_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_error <= 1'b0;
    end else if (w_xfer) begin
      r_m_valid <= 1'b1;
      r_m_data  <= s_data;
      r_m_error <= w_err;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_word_cnt      <= '0;
      r_run_cnt       <= '0;
      r_frame_done    <= 1'b0;
      r_frame_err_cnt <= '0;
`ifdef PARITY_IRQ_EN
      r_err_irq       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_word_cnt <= '0;
            r_run_cnt  <= '0;
`ifdef PARITY_IRQ_EN
            r_err_irq  <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (w_xfer) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
            if (w_err && (r_run_cnt != '1)) begin
              r_run_cnt <= r_run_cnt + CNT_W'(1);
            end
            if (w_last) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Count is published as DONE is entered so it is valid alongside frame_done.
          if (w_out_free) begin
            r_state         <= DONE;
            r_frame_done    <= 1'b1;
            r_frame_err_cnt <= r_run_cnt;
`ifdef PARITY_IRQ_EN
            if (r_run_cnt != '0) begin
              r_err_irq <= 1'b1;
            end
`endif
          end
        end
        DONE: begin
          r_frame_done <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign m_valid       = r_m_valid;
  assign m_data        = r_m_data;
  assign m_error       = r_m_error;
  assign frame_done    = r_frame_done;
  assign frame_err_cnt = r_frame_err_cnt;
`ifdef PARITY_IRQ_EN
  assign err_irq       = r_err_irq;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized bench for parity_frame_checker with a word-level scoreboard and per-frame error model.
module tb_parity_frame_checker;

  localparam int DW = 8;
  localparam int FL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_parity;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_error;
  logic          frame_done;
  logic [CW-1:0] frame_err_cnt;
`ifdef PARITY_IRQ_EN
  logic          err_irq;
`endif

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [DW:0]   out_q[$];
  logic [DW-1:0] fd[FL];
  logic          fp[FL];

  parity_frame_checker #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_parity      (s_parity),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_error       (m_error),
    .frame_done    (frame_done),
`ifdef PARITY_IRQ_EN
    .err_irq       (err_irq),
`endif
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  // Collect every word accepted downstream and every frame_done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) out_q.push_back({m_error, m_data});
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A word is in error when its count of ones is odd but the parity bit says even, or vice versa.
  function automatic logic model_err(input logic [DW-1:0] d, input logic p);
    int ones;
    ones = $countones(d);
    return ((ones % 2) == 1) != (p == 1'b1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input string name, input bit rand_rdy, input int stall_at,
                             input bit start_mid);
    logic [DW:0]   exp_q[$];
    logic [CW-1:0] exp_cnt;
    logic [DW:0]   held;
    int            done_before;
    bit            got;
    exp_cnt = '0;
    for (int i = 0; i < FL; i++) begin
      exp_q.push_back({model_err(fd[i], fp[i]), fd[i]});
      if (model_err(fd[i], fp[i])) exp_cnt = exp_cnt + 8'd1;
    end
    out_q.delete();
    done_before = done_cnt;

    m_ready = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy_after_start busy=%b expected=1", name, busy);
    if (busy !== 1'b1) failures++;
`ifdef PARITY_IRQ_EN
    checks++;
    if (err_irq !== 1'b0) begin
      $display("FAIL %s_irq_clear_on_start err_irq=%b expected=0", name, err_irq);
      failures++;
    end
`endif

    for (int i = 0; i < FL; i++) begin
      if (i == stall_at && i > 0) begin
        m_ready  = 1'b0;
        s_valid  = 1'b1;
        s_data   = fd[i];
        s_parity = fp[i];
        held     = exp_q[i-1];
        for (int c = 0; c < 5; c++) begin
          #1;
          checks++;
          if (s_ready !== 1'b0 || m_valid !== 1'b1 || {m_error, m_data} !== held) begin
            $display("FAIL %s_stall_cycle%0d s_ready=%b m_valid=%b out=%h expected s_ready=0 m_valid=1 out=%h",
                     name, c, s_ready, m_valid, {m_error, m_data}, held);
            failures++;
          end
          @(posedge clk);
          #1;
        end
      end
      s_valid  = 1'b1;
      s_data   = fd[i];
      s_parity = fp[i];
      start    = start_mid;
      got      = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        got = s_ready;
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      checks++;
      if (!got) begin
        $display("FAIL %s_accept_word%0d s_ready never high within 50 cycles, expected acceptance", name, i);
        failures++;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;

    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      got = frame_done;
    end
    checks++;
    if (!got) begin
      $display("FAIL %s_frame_done frame_done not seen within 20 cycles, expected a pulse", name);
      failures++;
    end
    checks++;
    if (frame_err_cnt !== exp_cnt) begin
      $display("FAIL %s_err_cnt frame_err_cnt=%0d expected=%0d", name, frame_err_cnt, exp_cnt);
      failures++;
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || frame_err_cnt !== exp_cnt) begin
      $display("FAIL %s_after_done frame_done=%b busy=%b cnt=%0d expected 0 0 %0d",
               name, frame_done, busy, frame_err_cnt, exp_cnt);
      failures++;
    end
    checks++;
    if (done_cnt !== done_before + 1) begin
      $display("FAIL %s_done_pulses count=%0d expected=%0d", name, done_cnt - done_before, 1);
      failures++;
    end
    checks++;
    if (out_q.size() != FL) begin
      $display("FAIL %s_word_count got=%0d expected=%0d", name, out_q.size(), FL);
      failures++;
    end else begin
      for (int i = 0; i < FL; i++) begin
        checks++;
        if (out_q[i] !== exp_q[i]) begin
          $display("FAIL %s_word%0d got err/data=%h expected=%h", name, i, out_q[i], exp_q[i]);
          failures++;
        end
      end
    end
`ifdef PARITY_IRQ_EN
    checks++;
    if (err_irq !== (exp_cnt != 0)) begin
      $display("FAIL %s_irq err_irq=%b expected=%b", name, err_irq, exp_cnt != 0);
      failures++;
    end
`endif
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || m_error !== 1'b0 ||
        frame_done !== 1'b0 || m_data !== 8'h00 || frame_err_cnt !== 8'h00) begin
      $display("FAIL %s busy=%b s_ready=%b m_valid=%b m_error=%b frame_done=%b m_data=%h cnt=%0d expected all zero",
               name, busy, s_ready, m_valid, m_error, frame_done, m_data, frame_err_cnt);
      failures++;
    end
`ifdef PARITY_IRQ_EN
    checks++;
    if (err_irq !== 1'b0) begin
      $display("FAIL %s_irq err_irq=%b expected=0", name, err_irq);
      failures++;
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_parity = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    check_reset_values("reset_state");
    rst_n = 1'b1;
    tick();
    check_reset_values("after_reset_release");
  endtask

  task automatic test_idle_valid();
    out_q.delete();
    s_valid = 1'b1; s_data = 8'h3C; s_parity = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL idle_valid_cycle%0d s_ready=%b busy=%b expected 0 0", c, s_ready, busy);
        failures++;
      end
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (out_q.size() != 0) begin
      $display("FAIL idle_valid_leak words_out=%0d expected=0", out_q.size());
      failures++;
    end
  endtask

  task automatic test_fixed_frames();
    fd = '{8'hAA, 8'h55, 8'hFF, 8'h0F}; fp = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive_frame("fixed1", 1'b0, -1, 1'b0);
    fd = '{8'hAA, 8'h00, 8'hF0, 8'h0F}; fp = '{1'b1, 1'b1, 1'b0, 1'b1};
    drive_frame("fixed2", 1'b0, -1, 1'b0);
    fd = '{8'h01, 8'h07, 8'h80, 8'hFE}; fp = '{1'b0, 1'b0, 1'b0, 1'b0};
    drive_frame("all_err", 1'b0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < FL; i++) begin fd[i] = 8'($urandom_range(0, 255)); fp[i] = 1'($urandom_range(0, 1)); end
    drive_frame("stall", 1'b0, 2, 1'b0);
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < FL; i++) begin fd[i] = 8'($urandom_range(0, 255)); fp[i] = 1'($urandom_range(0, 1)); end
    drive_frame("start_in_run", 1'b0, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < FL; i++) begin fd[i] = 8'($urandom_range(0, 255)); fp[i] = 1'($urandom_range(0, 1)); end
      drive_frame($sformatf("rand%0d", f), 1'b1, -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FL; i++) begin fd[i] = 8'($urandom_range(0, 255)); fp[i] = 1'($urandom_range(0, 1)); end
      drive_frame($sformatf("b2b%0d", f), 1'b0, -1, 1'b0);
    end
  endtask

  task automatic test_reset_midframe();
    int  done_before;
    bit  got;
    done_before = done_cnt;
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 8'h01; s_parity = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        #1;
        got = s_ready;
        @(posedge clk);
        #1;
      end
      checks++;
      if (!got) begin
        $display("FAIL midreset_accept_word%0d s_ready never high, expected acceptance", i);
        failures++;
      end
    end
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midframe_reset_immediate");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (done_cnt !== done_before) begin
      $display("FAIL midreset_no_done pulses=%0d expected=0", done_cnt - done_before);
      failures++;
    end
    fd = '{8'h03, 8'h00, 8'h00, 8'h00}; fp = '{1'b1, 1'b0, 1'b0, 1'b0};
    drive_frame("after_midreset", 1'b0, -1, 1'b0);
  endtask

  task automatic test_irq();
`ifdef PARITY_IRQ_EN
    fd = '{8'h01, 8'h00, 8'h00, 8'h00}; fp = '{1'b0, 1'b0, 1'b0, 1'b0};
    drive_frame("irq_one_err", 1'b0, -1, 1'b0);
    repeat (3) tick();
    checks++;
    if (err_irq !== 1'b1) begin
      $display("FAIL irq_held_idle err_irq=%b expected=1", err_irq);
      failures++;
    end
    fd = '{8'h00, 8'h00, 8'h00, 8'h00};
    drive_frame("irq_clean", 1'b0, -1, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_idle_valid();
    test_fixed_frames();
    test_backpressure();
    test_start_ignored();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
